// File: rtl/cube_scan_pkg.sv
// Shared types and constants for the cube layer scanner: FSM state encoding,
// default timing parameters and the timer width helper.
package cube_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LATCH,
        ST_SHOW,
        ST_BLANK
    } scan_state_e;

    localparam int DEF_NUM_LAYERS   = 16;
    localparam int DEF_ADDR_W       = 4;
    localparam int DEF_DWELL_CYCLES = 1000;
    localparam int DEF_BLANK_CYCLES = 8;
    localparam int DEF_LOAD_TIMEOUT = 4096;

    // One shared down-counter serves dwell, blank and load timeout, so it
    // must hold the largest reload value of the three.
    function automatic int timer_width(input int dwell, input int blank, input int timeout);
        int max_val;
        max_val = dwell;
        if (blank > max_val)
            max_val = blank;
        if (timeout > max_val)
            max_val = timeout;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cube_layer_scanner_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a
// reload of N-1 yields done on the Nth cycle after the load.
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - WIDTH'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/cube_layer_scanner.sv
// Layer multiplex sequencer: per layer requests a column load, latches it,
// drives the row for a fixed dwell, then holds a dark guard interval.
module cube_layer_scanner
    import cube_scan_pkg::*;
#(
    parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load_done,
    output logic              load_req,
    output logic [ADDR_W-1:0] load_layer,
    output logic              latch,
    output logic [ADDR_W-1:0] row_addr,
    output logic              row_en,
    output logic              frame_start,
    output logic              load_error
);

    localparam int TW = timer_width(DWELL_CYCLES, BLANK_CYCLES, LOAD_TIMEOUT);

    localparam logic [TW-1:0] DWELL_RELOAD   = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_RELOAD   = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_RELOAD = TW'(LOAD_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_LAYER = ADDR_W'(NUM_LAYERS - 1);

    scan_state_e       state;
    logic [ADDR_W-1:0] layer;
    logic [ADDR_W-1:0] next_layer;
    logic              timer_load;
    logic [TW-1:0]     timer_value;
    logic              timer_done;

    assign next_layer = (layer == LAST_LAYER) ? '0 : layer + ADDR_W'(1);

    // Timer reloads on every state entry, mirroring the transitions below.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (enable && !load_error) begin
                    timer_load  = 1'b1;
                    timer_value = TIMEOUT_RELOAD;
                end
            end
            ST_LOAD: begin
                if (load_done || timer_done)
                    timer_load = 1'b1;
            end
            ST_LATCH: begin
                timer_load  = 1'b1;
                timer_value = DWELL_RELOAD;
            end
            ST_SHOW: begin
                if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = BLANK_RELOAD;
                end
            end
            ST_BLANK: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (enable)
                        timer_value = TIMEOUT_RELOAD;
                end
            end
            default: ;
        endcase
    end

    scan_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (timer_load),
        .value(timer_value),
        .done (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            layer       <= '0;
            load_req    <= 1'b0;
            load_layer  <= '0;
            latch       <= 1'b0;
            row_addr    <= '0;
            row_en      <= 1'b0;
            frame_start <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            latch       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    row_en <= 1'b0;
                    if (enable && !load_error) begin
                        state       <= ST_LOAD;
                        layer       <= '0;
                        load_req    <= 1'b1;
                        load_layer  <= '0;
                        frame_start <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // A completed load wins over a timeout in the same cycle.
                    if (load_done) begin
                        state    <= ST_LATCH;
                        load_req <= 1'b0;
                        latch    <= 1'b1;
                        row_addr <= layer;
                    end else if (timer_done) begin
                        state      <= ST_IDLE;
                        load_req   <= 1'b0;
                        load_error <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    state  <= ST_SHOW;
                    row_en <= 1'b1;
                end
                ST_SHOW: begin
                    if (timer_done) begin
                        state  <= ST_BLANK;
                        row_en <= 1'b0;
                    end
                end
                ST_BLANK: begin
                    if (timer_done) begin
                        if (enable) begin
                            state       <= ST_LOAD;
                            layer       <= next_layer;
                            load_req    <= 1'b1;
                            load_layer  <= next_layer;
                            frame_start <= (next_layer == '0);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cube_layer_scanner.sv
// Directed bench for cube_layer_scanner with short timing parameters;
// outputs are sampled 1 ns after each rising edge.
module tb_cube_layer_scanner;

    localparam int NUM_LAYERS   = 16;
    localparam int ADDR_W       = 4;
    localparam int DWELL_CYCLES = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int LOAD_TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              load_done;
    logic              load_req;
    logic [ADDR_W-1:0] load_layer;
    logic              latch;
    logic [ADDR_W-1:0] row_addr;
    logic              row_en;
    logic              frame_start;
    logic              load_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cube_layer_scanner #(
        .NUM_LAYERS  (NUM_LAYERS),
        .ADDR_W      (ADDR_W),
        .DWELL_CYCLES(DWELL_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_done  (load_done),
        .load_req   (load_req),
        .load_layer (load_layer),
        .latch      (latch),
        .row_addr   (row_addr),
        .row_en     (row_en),
        .frame_start(frame_start),
        .load_error (load_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Compares all outputs packed as {load_req, load_layer, latch, row_addr, row_en, frame_start, load_error}.
    task automatic expect_out(input string tag, input logic lr, input logic [ADDR_W-1:0] ll,
                              input logic la, input logic [ADDR_W-1:0] ra, input logic re,
                              input logic fs, input logic le);
        check(tag,
              32'({load_req, load_layer, latch, row_addr, row_en, frame_start, load_error}),
              32'({lr, ll, la, ra, re, fs, le}));
    endtask

    initial begin
        logic [ADDR_W-1:0] cur;
        logic [ADDR_W-1:0] nxt;

        reset     = 1'b1;
        enable    = 1'b1;
        load_done = 1'b0;

        // Reset held three cycles with enable high: everything stays low.
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("reset_hold", 0, 0, 0, 0, 0, 0, 0);
        end

        reset = 1'b0;
        step();
        expect_out("first_load", 1, 0, 0, 0, 0, 1, 0);

        // Single-cycle load_done pulse.
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        expect_out("latch_l0", 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < DWELL_CYCLES; i++) begin
            step();
            expect_out("show_l0", 0, 0, 0, 0, 1, 0, 0);
        end
        for (int i = 0; i < BLANK_CYCLES; i++) begin
            step();
            expect_out("blank_l0", 0, 0, 0, 0, 0, 0, 0);
        end
        step();
        expect_out("load_l1", 1, 1, 0, 0, 0, 0, 0);

        // load_done tied high: 8-cycle layers, wrap 15 -> 0 with frame_start.
        load_done = 1'b1;
        cur = 4'd1;
        for (int n = 0; n < 17; n++) begin
            nxt = (cur == 4'd15) ? 4'd0 : cur + 4'd1;
            step();
            expect_out("scan_latch", 0, cur, 1, cur, 0, 0, 0);
            step();
            expect_out("scan_show_first", 0, cur, 0, cur, 1, 0, 0);
            step();
            step();
            step();
            expect_out("scan_show_last", 0, cur, 0, cur, 1, 0, 0);
            step();
            expect_out("scan_blank", 0, cur, 0, cur, 0, 0, 0);
            step();
            step();
            expect_out("scan_next_load", 1, nxt, 0, cur, 0, (nxt == 4'd0), 0);
            cur = nxt;
        end

        // Now in LOAD of layer 2; advance through layers 2..4.
        for (int i = 0; i < 3 * 8; i++)
            step();
        expect_out("load_l5", 1, 5, 0, 4, 0, 0, 0);
        step();
        expect_out("latch_l5", 0, 5, 1, 5, 0, 0, 0);
        step();
        step();
        // Drop enable mid-SHOW: dwell and blank still complete.
        enable = 1'b0;
        step();
        step();
        expect_out("show_l5_end", 0, 5, 0, 5, 1, 0, 0);
        step();
        step();
        expect_out("blank_l5_end", 0, 5, 0, 5, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("idle_no_l6", 0, 5, 0, 5, 0, 0, 0);
        end

        // Restart from IDLE, then reset during SHOW.
        enable = 1'b1;
        step();
        expect_out("restart_load", 1, 0, 0, 5, 0, 1, 0);
        step();
        expect_out("restart_latch", 0, 0, 1, 0, 0, 0, 0);
        step();
        expect_out("restart_show", 0, 0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        step();
        expect_out("reset_in_show", 0, 0, 0, 0, 0, 0, 0);
        reset     = 1'b0;
        load_done = 1'b0;
        step();
        expect_out("post_reset_load", 1, 0, 0, 0, 0, 1, 0);

        // No load_done: LOAD lasts exactly LOAD_TIMEOUT cycles, then fault.
        for (int i = 0; i < LOAD_TIMEOUT - 1; i++)
            step();
        expect_out("load_before_timeout", 1, 0, 0, 0, 0, 0, 0);
        step();
        expect_out("timeout_fault", 0, 0, 0, 0, 0, 0, 1);

        // Fault is sticky: enable high and stray load_done do not restart.
        for (int i = 0; i < 5; i++) begin
            load_done = (i == 2);
            step();
            expect_out("fault_idle", 0, 0, 0, 0, 0, 0, 1);
        end
        load_done = 1'b0;

        reset = 1'b1;
        step();
        expect_out("fault_cleared", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        expect_out("fault_restart", 1, 0, 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cube_layer_scanner.md
Name: cube_layer_scanner

Overview:
- Sequences the cube's layer multiplex: walks layer address 0..NUM_LAYERS-1.
- Per layer: requests column-data load from the shift-out block, latches the data, then enables the row for a fixed dwell.
- `row_addr` feeds the inverting layer decoder. Top level forces all decoder outputs inactive (all ones) whenever `row_en`=0.
- Guarantees a dark guard interval between layers, preventing ghosting.

Parameters:
- NUM_LAYERS, 16, layers per frame. Must be ≤ 2^ADDR_W.
- ADDR_W, 4, width of layer address; matches decoder input.
- DWELL_CYCLES, 1000, clocks `row_en` is high per layer; ≥1.
- BLANK_CYCLES, 8, dark guard clocks after each dwell; ≥1.
- LOAD_TIMEOUT, 4096, max clocks waiting for `load_done` before fault; ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; scanning runs while high.
- load_done  in  1  shift-out block finished loading `load_layer`; sampled only in LOAD.
- load_req  out  1  request column-data load; held until `load_done` is seen.
- load_layer  out  ADDR_W  layer whose data is requested; valid while `load_req`=1.
- latch  out  1  one-cycle pulse transferring shifted data to column outputs.
- row_addr  out  ADDR_W  layer address to decoder.
- row_en  out  1  row drive enable.
- frame_start  out  1  one-cycle pulse when layer 0 load begins.
- load_error  out  1  sticky load-timeout fault.

Behaviour:
- Clock and reset:
  - One clock `clk`; reset is synchronous and active-high.
  - On a reset edge: state=IDLE; all outputs 0; layer counter and timer 0. This applies mid-operation too; no outputs are held.
  - All outputs are registered.
- States: IDLE, LOAD, LATCH, SHOW, BLANK.
- IDLE:
  - `row_en`=0.
  - If `enable`=1 and `load_error`=0: next cycle enter LOAD with layer=0, `load_req`=1, `load_layer`=0, `frame_start`=1 for that cycle.
- LOAD:
  - `load_req`=1.
  - `load_done`=1 is accepted in any LOAD cycle, including the first.
  - On accept: next cycle enter LATCH with `load_req`=0.
  - Timer counts LOAD cycles. If LOAD_TIMEOUT cycles pass with no `load_done`: `load_error`←1, `load_req`←0, go to IDLE.
  - `load_error` is cleared only by reset.
- LATCH (1 cycle): `latch`=1; `row_addr`←layer; `row_en`=0.
- SHOW:
  - `row_en`=1 for exactly DWELL_CYCLES consecutive cycles; `row_addr` stable.
  - Then enter BLANK.
- BLANK:
  - `row_en`=0 for exactly BLANK_CYCLES cycles; `row_addr` holds.
  - At end, if `enable`=0: go to IDLE.
  - Otherwise go to LOAD with layer←layer+1. Layer wraps NUM_LAYERS-1→0; `frame_start` pulses on the wrap.
- `enable` deassertion:
  - Takes effect only at the end of BLANK; the current layer completes its dwell.
  - `enable` is ignored in LOAD, LATCH and SHOW.
- `load_done` outside LOAD is ignored. A `load_done` held high across states does not skip a load.
- Minimum layer period = 1 (LOAD) + 1 (LATCH) + DWELL_CYCLES + BLANK_CYCLES.
- `row_en` and `latch` are never high in the same cycle. `row_en` never rises without a preceding LATCH.
- Timer width = clog2(max(DWELL_CYCLES, BLANK_CYCLES, LOAD_TIMEOUT)+1). Timer reloads on every state entry.

Decomposition:
- Package `cube_scan_pkg` holds:
  - state enum
  - default parameter constants
  - helper function for timer width.
- One sub-module: `scan_timer`, a loadable down-counter with a `done` flag. Shared by SHOW, BLANK and LOAD-timeout.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, LOAD_TIMEOUT=8, NUM_LAYERS=16):
- Reset held 3 cycles, `enable`=1 → all outputs 0 throughout. First cycle after release: `load_req`=1, `load_layer`=0, `frame_start`=1.
- `load_done` pulsed 1 cycle after `load_req` rises → next cycle `latch`=1, `row_addr`=0. Then `row_en` high exactly 4 cycles, low 2, then `load_req`=1 with `load_layer`=1.
- `load_done` tied high, 16 layers → `row_addr` runs 0..15 then 0. `frame_start` pulses once per frame, 8 cycles per layer.
- `load_done` never asserted → after 8 LOAD cycles `load_error`=1, `load_req`=0, state IDLE. Stays IDLE with `enable`=1 until reset.
- `enable` dropped mid-SHOW of layer 5 → dwell completes 4 cycles, blank 2 cycles, then IDLE. No `load_req` for layer 6.
- Reset asserted during SHOW → next edge `row_en`=0, `row_addr`=0. Restart begins at layer 0 with `frame_start`.
